// File: rtl/pdh_cmd_master.sv
// pdh_cmd_master
//   PL-side initiator for the pdh_core command-word protocol. Takes one
//   request at a time, drives the PS->core command word through the
//   setup / strobe / acknowledge / release handshake and returns the
//   callback payload together with an error flag.
//
// Ports
//   clk, rst_n         system clock, synchronous active-low reset
//   req_valid_i        request valid
//   req_ready_o        request accepted when high together with valid
//   req_cmd_i          command code (0x1 LED, 0x2 DAC, 0x4 ADC)
//   req_data_i         26-bit command payload
//   req_core_rst_i     request is a core reset instead of a command
//   resp_valid_o       one-cycle response pulse
//   resp_cmd_o         callback[31:28] captured at acknowledge
//   resp_data_o        callback[26:0] captured at acknowledge
//   resp_err_o         timeout while waiting in STROBE or RELEASE
//   busy_o             high whenever the FSM is not idle
//   axi_from_ps_o      command word: [31] core rst, [30] strobe,
//                      [29:26] cmd, [25:0] data
//   axi_to_ps_i        callback word: [31:28] cmd echo, [27] strobe ack,
//                      [26:0] data

module pdh_cmd_master #(
  parameter int SETUP_CYC   = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [3:0]  req_cmd_i,
  input  logic [25:0] req_data_i,
  input  logic        req_core_rst_i,
  output logic        resp_valid_o,
  output logic [3:0]  resp_cmd_o,
  output logic [26:0] resp_data_o,
  output logic        resp_err_o,
  output logic        busy_o,
  output logic [31:0] axi_from_ps_o,
  input  logic [31:0] axi_to_ps_i
);

  localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);
  localparam int SU_W  = $clog2(SETUP_CYC + 1);
  localparam int CNT_W = (TO_W > SU_W) ? TO_W : SU_W;

  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CRST,
    S_SETUP,
    S_STROBE,
    S_RELEASE,
    S_RESP
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [3:0]        cmd_q, cmd_d;
  logic [25:0]       data_q, data_d;
  logic [31:0]       word_q, word_d;
  logic              ready_q, ready_d;
  logic              resp_valid_q, resp_valid_d;
  logic [3:0]        resp_cmd_q, resp_cmd_d;
  logic [26:0]       resp_data_q, resp_data_d;
  logic              resp_err_q, resp_err_d;
  logic              busy_q, busy_d;
  logic              accept;
  logic              ack_hit;

  // Next-state and response capture. Only an ack whose command echo
  // matches the latched command counts, so a stale or foreign callback
  // cannot complete the handshake. A strobe timeout zeroes the response
  // payload; a release timeout keeps what was captured at ack.
  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    data_d      = data_q;
    resp_cmd_d  = resp_cmd_q;
    resp_data_d = resp_data_q;
    resp_err_d  = resp_err_q;
    accept      = (state_q == S_IDLE) && ready_q && req_valid_i;
    ack_hit     = axi_to_ps_i[27] && (axi_to_ps_i[31:28] == cmd_q);

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          cmd_d      = req_cmd_i;
          data_d     = req_data_i;
          resp_err_d = 1'b0;
          if (req_core_rst_i) begin
            resp_cmd_d  = '0;
            resp_data_d = '0;
            state_d     = S_CRST;
          end else begin
            state_d = S_SETUP;
          end
        end
      end
      S_CRST: begin
        if (cnt_q == SETUP_LAST) state_d = S_RESP;
      end
      S_SETUP: begin
        if (cnt_q == SETUP_LAST) state_d = S_STROBE;
      end
      S_STROBE: begin
        if (ack_hit) begin
          resp_cmd_d  = axi_to_ps_i[31:28];
          resp_data_d = axi_to_ps_i[26:0];
          state_d     = S_RELEASE;
        end else if (cnt_q == TO_LAST) begin
          resp_err_d  = 1'b1;
          resp_cmd_d  = '0;
          resp_data_d = '0;
          state_d     = S_RELEASE;
        end
      end
      S_RELEASE: begin
        if (!axi_to_ps_i[27]) begin
          state_d = S_RESP;
        end else if (cnt_q == TO_LAST) begin
          resp_err_d = 1'b1;
          state_d    = S_RESP;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Cycle counter shared by the setup, core-reset and timeout phases.
  // It restarts on every state change and saturates instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  // Registered outputs are derived from the current state, which puts the
  // command word one cycle behind the state change. Outside a handshake
  // only the core-reset and strobe bits are cleared; cmd/data persist.
  // Ready is withheld on the accept edge and during the response cycle so
  // it returns one cycle after the response pulse.
  always_comb begin
    word_d = {2'b00, word_q[29:0]};
    case (state_q)
      S_CRST:              word_d = 32'h8000_0000;
      S_SETUP, S_RELEASE:  word_d = {2'b00, cmd_q, data_q};
      S_STROBE:            word_d = {2'b01, cmd_q, data_q};
      default:             word_d = {2'b00, word_q[29:0]};
    endcase
    ready_d      = (state_q == S_IDLE) && !accept;
    resp_valid_d = (state_q == S_RESP);
    busy_d       = (state_d != S_IDLE);
  end

  // State and output registers with synchronous active-low reset; a reset
  // mid-handshake drops strobe and core-reset on the very next edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      cmd_q        <= '0;
      data_q       <= '0;
      word_q       <= '0;
      ready_q      <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_cmd_q   <= '0;
      resp_data_q  <= '0;
      resp_err_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cmd_q        <= cmd_d;
      data_q       <= data_d;
      word_q       <= word_d;
      ready_q      <= ready_d;
      resp_valid_q <= resp_valid_d;
      resp_cmd_q   <= resp_cmd_d;
      resp_data_q  <= resp_data_d;
      resp_err_q   <= resp_err_d;
      busy_q       <= busy_d;
    end
  end

  assign axi_from_ps_o = word_q;
  assign req_ready_o   = ready_q;
  assign resp_valid_o  = resp_valid_q;
  assign resp_cmd_o    = resp_cmd_q;
  assign resp_data_o   = resp_data_q;
  assign resp_err_o    = resp_err_q;
  assign busy_o        = busy_q;

endmodule

// File: tb/tb_pdh_cmd_master.sv
// tb_pdh_cmd_master
//   Scoreboard bench for pdh_cmd_master. Stimulus pushes the response the
//   protocol rules predict for each request; a monitor pops and compares on
//   every resp_valid_o pulse. A behavioural pdh_core responder answers the
//   strobe in one of several modes (normal, silent, mismatched echo, ack
//   stuck high).

module tb_pdh_cmd_master;

  localparam int SETUP_CYC   = 4;
  localparam int TIMEOUT_CYC = 16;

  localparam int MODE_NORMAL   = 0;
  localparam int MODE_SILENT   = 1;
  localparam int MODE_MISMATCH = 2;
  localparam int MODE_STUCK    = 3;

  typedef struct packed {
    logic [3:0]  cmd;
    logic [26:0] data;
    logic        err;
  } resp_t;

  logic        clk;
  logic        rst_n;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [3:0]  req_cmd_i;
  logic [25:0] req_data_i;
  logic        req_core_rst_i;
  logic        resp_valid_o;
  logic [3:0]  resp_cmd_o;
  logic [26:0] resp_data_o;
  logic        resp_err_o;
  logic        busy_o;
  logic [31:0] axi_from_ps_o;
  logic [31:0] axi_to_ps_i;

  resp_t       exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          resp_seen = 0;
  int          resp_expected = 0;
  int          cycle_cnt = 0;
  int          last_resp_cycle = 0;

  int          rsp_mode = MODE_NORMAL;
  int          rsp_delay = 1;
  logic [26:0] rsp_echo = '0;
  logic [3:0]  rsp_mis_cmd = '0;
  int          strobe_cnt = 0;

  logic        trace_on = 1'b0;
  logic [31:0] word_trace[$];
  logic        prev_valid = 1'b0;

  pdh_cmd_master #(
    .SETUP_CYC   (SETUP_CYC),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .req_cmd_i      (req_cmd_i),
    .req_data_i     (req_data_i),
    .req_core_rst_i (req_core_rst_i),
    .resp_valid_o   (resp_valid_o),
    .resp_cmd_o     (resp_cmd_o),
    .resp_data_o    (resp_data_o),
    .resp_err_o     (resp_err_o),
    .busy_o         (busy_o),
    .axi_from_ps_o  (axi_from_ps_o),
    .axi_to_ps_i    (axi_to_ps_i)
  );

  // Free-running clock and a cycle counter used for latency measurements.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  // Global safety net so the run can never hang.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, checks %0d", checks);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic reportTimeout(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: wait bound expired, got no event, expected one", name);
  endtask

  // Reference model: the response each responder behaviour must produce.
  function automatic resp_t predict(input int mode, input logic crst,
                                    input logic [3:0] cmd, input logic [26:0] echo);
    resp_t e;
    e = '0;
    if (!crst) begin
      if (mode == MODE_NORMAL) begin
        e.cmd  = cmd;
        e.data = echo;
      end else if (mode == MODE_STUCK) begin
        e.cmd  = cmd;
        e.data = echo;
        e.err  = 1'b1;
      end else begin
        e.err = 1'b1;
      end
    end
    return e;
  endfunction

  // Behavioural pdh_core: looks at the command word just after each edge
  // and answers according to rsp_mode. Idles at zero whenever the master
  // is not busy.
  initial begin
    axi_to_ps_i = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!busy_o) begin
        axi_to_ps_i = '0;
        strobe_cnt  = 0;
      end else begin
        case (rsp_mode)
          MODE_NORMAL, MODE_STUCK: begin
            if (axi_from_ps_o[30]) begin
              strobe_cnt++;
              if (strobe_cnt >= rsp_delay)
                axi_to_ps_i = {axi_from_ps_o[29:26], 1'b1, rsp_echo};
            end else if (rsp_mode == MODE_NORMAL) begin
              axi_to_ps_i = '0;
            end
          end
          MODE_MISMATCH: axi_to_ps_i = {rsp_mis_cmd, 1'b1, rsp_echo};
          default:       axi_to_ps_i = '0;
        endcase
      end
    end
  end

  // Command-word trace for the directed sequence checks.
  initial begin
    forever begin
      @(negedge clk);
      if (trace_on) word_trace.push_back(axi_from_ps_o);
    end
  end

  // Scoreboard monitor: every response pulse pops one prediction.
  initial begin
    resp_t e;
    forever begin
      @(negedge clk);
      if (resp_valid_o === 1'b1) begin
        last_resp_cycle = cycle_cnt;
        checkOutput("resp_single_pulse", prev_valid, 1'b0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL resp_unexpected: got a response, expected none (cmd 0x%0h)", resp_cmd_o);
        end else begin
          e = exp_q.pop_front();
          resp_seen++;
          checkOutput("resp_cmd", resp_cmd_o, e.cmd);
          checkOutput("resp_data", resp_data_o, e.data);
          checkOutput("resp_err", resp_err_o, e.err);
        end
      end
      prev_valid = resp_valid_o;
    end
  end

  // Issue one request, hold valid for 'hold' extra cycles while busy,
  // then wait for the transaction to finish and ready to return.
  task automatic applyStimulus(input logic [3:0] cmd, input logic [25:0] data,
                               input logic crst, input int mode, input int delay,
                               input logic [26:0] echo, input int hold,
                               output int lat_resp, output int lat_ready);
    bit acc;
    bit done;
    int acc_cycle;
    lat_resp  = -1;
    lat_ready = -1;
    exp_q.push_back(predict(mode, crst, cmd, echo));
    resp_expected++;
    @(negedge clk);
    rsp_mode       = mode;
    rsp_delay      = delay;
    rsp_echo       = echo;
    req_valid_i    = 1'b1;
    req_cmd_i      = cmd;
    req_data_i     = data;
    req_core_rst_i = crst;
    acc = 0;
    for (int i = 0; i < 64; i++) begin
      if (req_ready_o) begin
        acc = 1;
        break;
      end
      @(negedge clk);
    end
    if (!acc) begin
      reportTimeout("req_accept");
      req_valid_i = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    acc_cycle = cycle_cnt;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      checkOutput("ready_low_while_busy", req_ready_o, 1'b0);
      checkOutput("busy_high_during_hold", busy_o, 1'b1);
    end
    req_valid_i = 1'b0;
    done = 0;
    for (int i = 0; i < 4 * TIMEOUT_CYC + 4 * SETUP_CYC + 40; i++) begin
      @(negedge clk);
      if (!busy_o) begin
        done = 1;
        break;
      end
    end
    if (!done) begin
      reportTimeout("transaction_done");
      return;
    end
    lat_resp = last_resp_cycle - acc_cycle;
    done = 0;
    for (int i = 0; i < 8; i++) begin
      if (req_ready_o) begin
        done = 1;
        break;
      end
      @(negedge clk);
    end
    if (!done) reportTimeout("ready_return");
    else       lat_ready = cycle_cnt - acc_cycle;
  endtask

  // Run-length compress the word trace: run 0 is the word before the
  // request, then the setup/core-reset word, the strobe word, the release.
  task automatic checkWordTrace(input string tag, input logic [31:0] w1, input int len1,
                                input logic [31:0] w2, input int len2,
                                input bit check_third, input logic [31:0] w3);
    logic [31:0] rv[$];
    int          rl[$];
    int          need;
    foreach (word_trace[i]) begin
      if (rv.size() == 0 || rv[rv.size()-1] !== word_trace[i]) begin
        rv.push_back(word_trace[i]);
        rl.push_back(1);
      end else begin
        rl[rl.size()-1] = rl[rl.size()-1] + 1;
      end
    end
    need = check_third ? 4 : 3;
    checkOutput({tag, "_run_count_ok"}, (rv.size() >= need), 1'b1);
    if (rv.size() >= need) begin
      checkOutput({tag, "_first_word"}, rv[1], w1);
      checkOutput({tag, "_first_len"}, rl[1], len1);
      checkOutput({tag, "_second_word"}, rv[2], w2);
      if (len2 > 0) checkOutput({tag, "_second_len"}, rl[2], len2);
      if (check_third) checkOutput({tag, "_third_word"}, rv[3], w3);
    end
  endtask

  initial begin
    int          lr;
    int          lrdy;
    int          kind;
    logic [31:0] r32;
    logic [3:0]  cmd;
    logic [3:0]  cmd_tab[3];
    bit          seen;

    cmd_tab[0] = 4'h1;
    cmd_tab[1] = 4'h2;
    cmd_tab[2] = 4'h4;

    rst_n          = 1'b0;
    req_valid_i    = 1'b0;
    req_cmd_i      = '0;
    req_data_i     = '0;
    req_core_rst_i = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_word", axi_from_ps_o, 32'h0);
    checkOutput("reset_ready", req_ready_o, 1'b1);
    checkOutput("reset_busy", busy_o, 1'b0);
    checkOutput("reset_resp_valid", resp_valid_o, 1'b0);
    rst_n = 1'b1;
    $display("[TB] reset released");

    word_trace.delete();
    trace_on = 1'b1;
    applyStimulus(4'h1, 26'h55, 1'b0, MODE_NORMAL, 2, 27'h55, 0, lr, lrdy);
    trace_on = 1'b0;
    checkWordTrace("led", 32'h0400_0055, SETUP_CYC, 32'h4400_0055, 3, 1'b1, 32'h0400_0055);

    word_trace.delete();
    trace_on = 1'b1;
    applyStimulus(4'h2, 26'h5ABC, 1'b0, MODE_NORMAL, 3, 27'h5ABC, 6, lr, lrdy);
    trace_on = 1'b0;
    checkWordTrace("dac", 32'h0800_5ABC, SETUP_CYC, 32'h4800_5ABC, 4, 1'b1, 32'h0800_5ABC);

    word_trace.delete();
    trace_on = 1'b1;
    applyStimulus(4'h4, 26'h123, 1'b0, MODE_SILENT, 1, 27'h0, 0, lr, lrdy);
    trace_on = 1'b0;
    checkWordTrace("timeout", 32'h1000_0123, SETUP_CYC, 32'h5000_0123, TIMEOUT_CYC, 1'b1, 32'h1000_0123);

    rsp_mis_cmd = 4'h4;
    word_trace.delete();
    trace_on = 1'b1;
    applyStimulus(4'h2, 26'h3C3, 1'b0, MODE_MISMATCH, 1, 27'h3C3, 0, lr, lrdy);
    trace_on = 1'b0;
    checkWordTrace("mismatch", 32'h0800_03C3, SETUP_CYC, 32'h4800_03C3, TIMEOUT_CYC, 1'b1, 32'h0800_03C3);

    applyStimulus(4'h1, 26'h2AA, 1'b0, MODE_NORMAL, 1, 27'h7FF_FFFF, 0, lr, lrdy);
    checkOutput("accept_to_resp_cycles", lr, SETUP_CYC + 5);
    checkOutput("accept_to_ready_cycles", lrdy, SETUP_CYC + 6);

    word_trace.delete();
    trace_on = 1'b1;
    applyStimulus(4'h1, 26'h3FF_FFFF, 1'b1, MODE_NORMAL, 1, 27'h0, 0, lr, lrdy);
    trace_on = 1'b0;
    checkWordTrace("core_rst", 32'h8000_0000, SETUP_CYC, 32'h0, 0, 1'b0, 32'h0);

    applyStimulus(4'h4, 26'h1, 1'b0, MODE_STUCK, 2, 27'h123_4567, 0, lr, lrdy);

    for (int n = 0; n < 24; n++) begin
      kind = $urandom_range(0, 9);
      r32  = $urandom;
      cmd  = cmd_tab[$urandom_range(0, 2)];
      rsp_mis_cmd = cmd ^ 4'h8;
      case (kind)
        0:       applyStimulus(cmd, r32[25:0], 1'b1, MODE_NORMAL, 1, 27'h0, 0, lr, lrdy);
        1:       applyStimulus(cmd, r32[25:0], 1'b0, MODE_SILENT, 1, 27'h0, 0, lr, lrdy);
        2:       applyStimulus(cmd, r32[25:0], 1'b0, MODE_MISMATCH, 1, 27'h0, 0, lr, lrdy);
        3: begin
          r32 = $urandom;
          applyStimulus(cmd, r32[31:6], 1'b0, MODE_STUCK, $urandom_range(1, 5), r32[26:0], 0, lr, lrdy);
        end
        default: begin
          r32 = $urandom;
          applyStimulus(cmd, r32[25:0], 1'b0, MODE_NORMAL, $urandom_range(1, 5), r32[31:5], 0, lr, lrdy);
        end
      endcase
    end

    // Reset pulse in the middle of a strobe: no response is predicted.
    rsp_mode = MODE_SILENT;
    @(negedge clk);
    req_valid_i    = 1'b1;
    req_cmd_i      = 4'h2;
    req_data_i     = 26'h0ABCDEF;
    req_core_rst_i = 1'b0;
    seen = 0;
    for (int i = 0; i < 16; i++) begin
      if (req_ready_o) begin
        seen = 1;
        break;
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    req_valid_i = 1'b0;
    if (!seen) reportTimeout("midreset_accept");
    seen = 0;
    for (int i = 0; i < SETUP_CYC + 8; i++) begin
      @(negedge clk);
      if (axi_from_ps_o[30]) begin
        seen = 1;
        break;
      end
    end
    if (!seen) reportTimeout("midreset_strobe_seen");
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("midreset_word", axi_from_ps_o, 32'h0);
    checkOutput("midreset_ready", req_ready_o, 1'b1);
    checkOutput("midreset_busy", busy_o, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    repeat (10) @(negedge clk);
    checkOutput("scoreboard_drained", exp_q.size(), 0);
    checkOutput("response_count", resp_seen, resp_expected);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
